// File: rtl/contador_lotes_param_pkg.sv
// Shared constants and helpers for the bottling-line packing counter.
// Holds the default line constants (bottles per pack, packs per batch,
// synchroniser depth), the batch-end mode encodings, and a width helper.
// The helper is used when parameters are checked at elaboration.
package contador_lotes_param_pkg;

  // Line defaults: a dozen bottles per pack and ten packs per batch.
  localparam int DUZIA           = 12;
  localparam int MAX_LOTES       = 10;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int ITEM_W_DEF      = 4;
  localparam int PACK_W_DEF      = 7;

  // What happens when a batch of MAX_PACKS packs completes.
  typedef enum logic {
    MODE_SATURATE = 1'b0,  // stop counting, raise full, wait for an operator ack
    MODE_WRAP     = 1'b1   // clear the pack count and keep going
  } wrap_mode_e;

  // True when the unsigned value can be held in a field of the given width.
  function automatic bit fits_in(input int value, input int width);
    return (longint'(value) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/contador_lotes_param_if.sv
// Bus between the packing counter and its environment.
// It carries the sensor, the control inputs, the counter values and the flags.
// The master side drives the sensor and control inputs.
// The slave side (the counter) drives the counts and the flags.
interface contador_lotes_param_if #(
  parameter int ITEM_W = 4,
  parameter int PACK_W = 7
);

  logic              item_in;     // raw bottle sensor, asynchronous level
  logic              enable;      // accept bottle events
  logic              clear;       // synchronous clear of counters and flags
  logic              full_ack;    // operator acknowledge of a full batch
  logic [ITEM_W-1:0] item_count;  // bottles in the current pack
  logic [PACK_W-1:0] pack_count;  // completed packs
  logic              pack_pulse;  // one cycle per completed pack
  logic              wrap_pulse;  // one cycle per completed batch
  logic              full;        // batch complete, counting blocked

  modport master (
    output item_in, enable, clear, full_ack,
    input  item_count, pack_count, pack_pulse, wrap_pulse, full
  );

  modport slave (
    input  item_in, enable, clear, full_ack,
    output item_count, pack_count, pack_pulse, wrap_pulse, full
  );

endinterface

// File: rtl/contador_lotes_param_sincronizador_borda.sv
// Synchroniser and rising-edge detector for the bottle sensor.
// The raw sensor level goes through SYNC_STAGES flops. A last-value flop
// follows them, and evt is high for one cycle per synchronised rising edge.
// None of these flops has a synchronous clear. They keep tracking the sensor
// while counting is disabled, so re-enabling with the sensor already high
// never looks like a new edge.
module sincronizador_borda #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Shift the raw level through the synchroniser and remember the last synced value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Both operands come straight from flops, so evt is glitch-free inside the clock domain.
  assign evt = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/contador_lotes_param.sv
// Parametrised packing counter for the bottling line.
// Approved bottles from the final-station sensor are grouped into packs of
// ITEMS_PER_PACK. Completed packs are counted up to MAX_PACKS per batch. At the
// end of a batch the counter either wraps, or saturates and waits for an
// operator acknowledge. All outputs come straight from flops.
module contador_lotes_param
  import contador_lotes_param_pkg::*;
#(
  parameter int ITEMS_PER_PACK = DUZIA,
  parameter int MAX_PACKS      = MAX_LOTES,
  parameter int ITEM_W         = ITEM_W_DEF,
  parameter int PACK_W         = PACK_W_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int WRAP_MODE      = 1
) (
  input logic                   clk,
  input logic                   reset,
  contador_lotes_param_if.slave bus
);

  // Terminal values compared against every cycle, sized to their counters.
  localparam logic [ITEM_W-1:0] ITEM_LAST = ITEM_W'(ITEMS_PER_PACK - 1);
  localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(MAX_PACKS - 1);
  localparam logic [PACK_W-1:0] PACK_MAX  = PACK_W'(MAX_PACKS);
  localparam logic              WRAP_EN   = (WRAP_MODE == int'(MODE_WRAP));

  // Illegal parameter combinations stop elaboration instead of silently misbehaving.
  if (ITEMS_PER_PACK < 2) begin : g_bad_items
    $error("contador_lotes_param: ITEMS_PER_PACK must be >= 2");
  end
  if (MAX_PACKS < 1) begin : g_bad_packs
    $error("contador_lotes_param: MAX_PACKS must be >= 1");
  end
  if (!fits_in(ITEMS_PER_PACK - 1, ITEM_W)) begin : g_bad_item_w
    $error("contador_lotes_param: ITEM_W too narrow for ITEMS_PER_PACK-1");
  end
  if (!fits_in(MAX_PACKS, PACK_W)) begin : g_bad_pack_w
    $error("contador_lotes_param: PACK_W too narrow for MAX_PACKS");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("contador_lotes_param: SYNC_STAGES must be >= 2");
  end
  if ((WRAP_MODE != int'(MODE_WRAP)) && (WRAP_MODE != int'(MODE_SATURATE))) begin : g_bad_mode
    $error("contador_lotes_param: WRAP_MODE must be 0 or 1");
  end

  logic              evt_s;
  logic              accept_s;
  logic              ack_s;
  logic [ITEM_W-1:0] item_count_r;
  logic [PACK_W-1:0] pack_count_r;
  logic              pack_pulse_r;
  logic              wrap_pulse_r;
  logic              full_r;

  sincronizador_borda #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sincronizador_borda (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.item_in),
    .evt      (evt_s)
  );

  // An event is dropped, never queued, when disabled, blocked by full or clear.
  assign accept_s = evt_s & bus.enable & ~full_r & ~bus.clear;

  // The acknowledge only means something in saturate mode while the batch is full.
  assign ack_s = ~WRAP_EN & bus.full_ack & full_r;

  // Counters, batch flag and one-cycle pulses; clear outranks acknowledge and counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      item_count_r <= '0;
      pack_count_r <= '0;
      pack_pulse_r <= 1'b0;
      wrap_pulse_r <= 1'b0;
      full_r       <= 1'b0;
    end else if (bus.clear) begin
      item_count_r <= '0;
      pack_count_r <= '0;
      pack_pulse_r <= 1'b0;
      wrap_pulse_r <= 1'b0;
      full_r       <= 1'b0;
    end else begin
      pack_pulse_r <= 1'b0;
      wrap_pulse_r <= 1'b0;
      if (ack_s) begin
        item_count_r <= '0;
        pack_count_r <= '0;
        full_r       <= 1'b0;
      end else if (accept_s) begin
        if (item_count_r == ITEM_LAST) begin
          // Last bottle of the pack: close the pack and advance the batch.
          item_count_r <= '0;
          pack_pulse_r <= 1'b1;
          if (pack_count_r == PACK_LAST) begin
            wrap_pulse_r <= 1'b1;
            if (WRAP_EN) begin
              pack_count_r <= '0;
            end else begin
              pack_count_r <= PACK_MAX;
              full_r       <= 1'b1;
            end
          end else begin
            pack_count_r <= pack_count_r + 1'b1;
          end
        end else begin
          item_count_r <= item_count_r + 1'b1;
        end
      end else begin
        item_count_r <= item_count_r;
        pack_count_r <= pack_count_r;
        full_r       <= full_r;
      end
    end
  end

  assign bus.item_count = item_count_r;
  assign bus.pack_count = pack_count_r;
  assign bus.pack_pulse = pack_pulse_r;
  assign bus.wrap_pulse = wrap_pulse_r;
  assign bus.full       = full_r;

endmodule
